// File: rtl/uart_tx_arbiter_if.sv
// Handshake and uart_tx-side bus for uart_tx_arbiter.
// master: the arbiter. slave: the producers plus uart_tx, or a testbench.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned REQ_IDW = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [REQ_IDW-1:0]   grant_id;
    logic                 active;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// A byte is accepted in IDLE, tx_start pulses the following cycle, and no
// further grant is made until uart_tx has raised and then dropped busy.
// Optional feature macro UART_ARB_TIMEOUT_EN: adds arb_err and a watchdog that
// drops the byte if busy is not seen within 4 cycles of WAIT_BUSY.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned REQ_IDW = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef UART_ARB_TIMEOUT_EN
    output logic arb_err,
`endif
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    state_e             state_q, state_d;
    logic [REQ_IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_IDW-1:0] grant_id_q, grant_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               active_q, active_d;

    logic               win_found;
    logic [REQ_IDW-1:0] win_idx;
    logic [REQ_IDW:0]   cand;
    logic               accept;

`ifdef UART_ARB_TIMEOUT_EN
    logic [2:0] wd_cnt_q, wd_cnt_d;
    logic       arb_err_q, arb_err_d;
`endif

    // Winner search: first valid requester starting at rr_ptr, wrapping explicitly.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (REQ_IDW+1)'(k);
            if (cand >= (REQ_IDW+1)'(NUM_REQ)) begin
                cand = cand - (REQ_IDW+1)'(NUM_REQ);
            end
            if (!win_found && bus.req_valid[cand[REQ_IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[REQ_IDW-1:0];
            end
        end
    end

    // Gated on reset so no byte is acknowledged and then lost during reset.
    assign accept = (state_q == StIdle) && win_found && !bus.tx_busy && !reset;

    // One-hot ready towards the winning requester only.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        active_d   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
        arb_err_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_data_d  = bus.req_data[{win_idx, 3'b000} +: 8];
                    grant_id_d = win_idx;
                    active_d   = 1'b1;
                    rr_ptr_d   = (win_idx == REQ_IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
`ifdef UART_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            StWaitBusy: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt_q == 3'd3) begin
                    arb_err_d = 1'b1;
                    active_d  = 1'b0;
                    state_d   = StIdle;
                end else begin
                    wd_cnt_d = wd_cnt_q + 3'd1;
                end
`endif
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q   <= '0;
            arb_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
            arb_err_q  <= arb_err_d;
`endif
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.active   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign arb_err      = arb_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .REQ_IDW(2)) bif ();

`ifdef UART_ARB_TIMEOUT_EN
    logic arb_err;
`endif

    uart_tx_arbiter #(.NUM_REQ(4), .REQ_IDW(2)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef UART_ARB_TIMEOUT_EN
        .arb_err (arb_err),
`endif
        .bus     (bif.master)
    );

    // uart_tx stand-in: busy rises the cycle after tx_start and stays high 10 cycles.
    logic       model_en = 1'b0;
    logic       man_busy = 1'b0;
    logic       mbusy;
    logic [3:0] mcnt;
    always @(posedge clk) begin
        if (reset) begin
            mbusy <= 1'b0;
            mcnt  <= 4'd0;
        end else if (mbusy) begin
            if (mcnt == 4'd1) mbusy <= 1'b0;
            mcnt <= mcnt - 4'd1;
        end else if (bif.tx_start) begin
            mbusy <= 1'b1;
            mcnt  <= 4'd10;
        end
    end
    assign bif.tx_busy = model_en ? mbusy : man_busy;

    int errors = 0;
    int checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bif.req_valid = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_inactive(input string name);
        int n;
        n = 0;
        while (bif.active && n < 60) begin
            tick;
            n++;
        end
        checks++;
        if (bif.active !== 1'b0) begin
            errors++;
            $display("FAIL %s: active still %b after %0d cycles, want 0", name, bif.active, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bif.req_valid = 4'b0000;
        bif.req_data = '0;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks += 4;
            if (bif.tx_start !== 1'b0) begin
                errors++; $display("FAIL reset_tx_start c%0d: got %b want 0", i, bif.tx_start);
            end
            if (bif.active !== 1'b0) begin
                errors++; $display("FAIL reset_active c%0d: got %b want 0", i, bif.active);
            end
            if (bif.req_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_ready c%0d: got %b want 0000", i, bif.req_ready);
            end
            if (bif.grant_id !== 2'd0) begin
                errors++; $display("FAIL reset_grant c%0d: got %0d want 0", i, bif.grant_id);
            end
        end
        checks++;
        if (bif.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %h want 00", bif.tx_data);
        end
    endtask

    task automatic test_single;
        reset = 1'b0;
        model_en = 1'b0;
        man_busy = 1'b0;
        bif.req_data = 32'h00A5_0000;
        bif.req_valid = 4'b0100;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b want 0100", bif.req_ready);
        end
        tick;
        checks += 4;
        if (bif.tx_start !== 1'b1) begin
            errors++; $display("FAIL single_start: got %b want 1", bif.tx_start);
        end
        if (bif.tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h want a5", bif.tx_data);
        end
        if (bif.grant_id !== 2'd2) begin
            errors++; $display("FAIL single_grant: got %0d want 2", bif.grant_id);
        end
        if (bif.active !== 1'b1) begin
            errors++; $display("FAIL single_active: got %b want 1", bif.active);
        end
        // Data changing after acceptance must not reach tx_data.
        bif.req_data = 32'h00FF_0000;
        bif.req_valid = 4'b0000;
        tick;
        checks += 2;
        if (bif.tx_start !== 1'b0) begin
            errors++; $display("FAIL single_start_pulse: got %b want 0", bif.tx_start);
        end
        if (bif.tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_data_hold: got %h want a5", bif.tx_data);
        end
        man_busy = 1'b1;
        tick;
        checks++;
        if (bif.active !== 1'b1) begin
            errors++; $display("FAIL single_active_busy: got %b want 1", bif.active);
        end
        man_busy = 1'b0;
        tick;
        checks++;
        if (bif.active !== 1'b0) begin
            errors++; $display("FAIL single_active_done: got %b want 0", bif.active);
        end
    endtask

    task automatic test_round_robin;
        int n;
        int since;
        logic [7:0] exp_data;
        do_reset;
        model_en = 1'b1;
        bif.req_data = 32'h1312_1110;
        bif.req_valid = 4'b1111;
        since = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                tick;
                n++;
                since++;
            end while (!bif.tx_start && n < 60);
            exp_data = 8'h10 + 8'(i % 4);
            checks += 2;
            if (bif.tx_start !== 1'b1) begin
                errors++; $display("FAIL rr_timeout #%0d: no tx_start in %0d cycles", i, n);
            end
            if (bif.tx_data !== exp_data || bif.grant_id !== 2'(i % 4)) begin
                errors++;
                $display("FAIL rr_order #%0d: got data %h id %0d want data %h id %0d",
                         i, bif.tx_data, bif.grant_id, exp_data, i % 4);
            end
            if (i > 0) begin
                checks++;
                if (since != 13) begin
                    errors++; $display("FAIL rr_spacing #%0d: got %0d want 13", i, since);
                end
            end
            since = 0;
        end
        bif.req_valid = 4'b0000;
        wait_inactive("rr_drain");
    endtask

    task automatic test_drop;
        do_reset;
        model_en = 1'b0;
        man_busy = 1'b0;
        bif.req_data = 32'hD3C2_B1A0;
        bif.req_valid = 4'b0001;
        tick;
        checks++;
        if (bif.grant_id !== 2'd0 || bif.tx_start !== 1'b1) begin
            errors++;
            $display("FAIL drop_setup: got id %0d start %b want id 0 start 1",
                     bif.grant_id, bif.tx_start);
        end
        bif.req_valid = 4'b0000;
        tick;
        man_busy = 1'b1;
        tick;
        man_busy = 1'b0;
        tick;
        // Idle with rr_ptr=1; busy still high holds off any grant.
        man_busy = 1'b1;
        bif.req_valid = 4'b1010;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0000) begin
            errors++; $display("FAIL drop_busy_hold: got %b want 0000", bif.req_ready);
        end
        tick;
        checks++;
        if (bif.tx_start !== 1'b0 || bif.active !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_start: got start %b active %b want 0 0",
                     bif.tx_start, bif.active);
        end
        bif.req_valid = 4'b1000;
        man_busy = 1'b0;
        #1;
        checks++;
        if (bif.req_ready !== 4'b1000) begin
            errors++; $display("FAIL drop_ready3: got %b want 1000", bif.req_ready);
        end
        tick;
        checks++;
        if (bif.tx_start !== 1'b1 || bif.grant_id !== 2'd3 || bif.tx_data !== 8'hD3) begin
            errors++;
            $display("FAIL drop_grant3: got start %b id %0d data %h want 1 3 d3",
                     bif.tx_start, bif.grant_id, bif.tx_data);
        end
        bif.req_valid = 4'b0000;
        tick;
        man_busy = 1'b1;
        tick;
        man_busy = 1'b0;
        tick;
        // rr_ptr wrapped 3 -> 0, so requester 0 beats requester 1.
        bif.req_valid = 4'b0011;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0001) begin
            errors++; $display("FAIL drop_wrap: got %b want 0001", bif.req_ready);
        end
        bif.req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset;
        model_en = 1'b1;
        bif.req_data = 32'h4433_2211;
        bif.req_valid = 4'b0100;
        n = 0;
        do begin
            tick;
            n++;
        end while (!bif.tx_start && n < 20);
        bif.req_valid = 4'b0000;
        tick;
        tick;
        checks++;
        if (bif.active !== 1'b1) begin
            errors++; $display("FAIL mid_active_before: got %b want 1", bif.active);
        end
        reset = 1'b1;
        bif.req_valid = 4'b1010;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_ready_in_reset: got %b want 0000", bif.req_ready);
        end
        tick;
        checks++;
        if (bif.tx_start !== 1'b0 || bif.active !== 1'b0 || bif.grant_id !== 2'd0
            || bif.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outs: got start %b active %b id %0d data %h want 0 0 0 00",
                     bif.tx_start, bif.active, bif.grant_id, bif.tx_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_ready_after: got %b want 0010", bif.req_ready);
        end
        tick;
        checks++;
        if (bif.grant_id !== 2'd1 || bif.tx_data !== 8'h22 || bif.tx_start !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant_after: got id %0d data %h start %b want 1 22 1",
                     bif.grant_id, bif.tx_data, bif.tx_start);
        end
        bif.req_valid = 4'b0000;
        wait_inactive("mid_drain");
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset;
        model_en = 1'b0;
        man_busy = 1'b0;
        bif.req_data = 32'h0000_5A00;
        bif.req_valid = 4'b0001;
        tick;
        bif.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (arb_err !== 1'b0 || bif.active !== 1'b1) begin
                errors++;
                $display("FAIL to_wait c%0d: got err %b active %b want 0 1",
                         i, arb_err, bif.active);
            end
        end
        tick;
        checks++;
        if (arb_err !== 1'b1 || bif.active !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: got err %b active %b want 1 0", arb_err, bif.active);
        end
        bif.req_valid = 4'b0010;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0010) begin
            errors++; $display("FAIL to_reaccept: got %b want 0010", bif.req_ready);
        end
        tick;
        checks++;
        if (arb_err !== 1'b0 || bif.tx_start !== 1'b1 || bif.tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL to_next: got err %b start %b data %h want 0 1 5a",
                     arb_err, bif.tx_start, bif.tx_data);
        end
        bif.req_valid = 4'b0000;
        do_reset;
    endtask
`endif

    initial begin
        bif.req_valid = '0;
        bif.req_data = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_drop;
        test_reset_mid;
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte requesters. Each requester presents bytes on a valid/ready handshake. The arbiter selects one requester, latches its byte, and drives the uart_tx start/data_in inputs. It holds off further grants until uart_tx has raised and then dropped busy. It sits between the producer blocks (console, debug, status) and uart_tx, which keeps its own baud tick generator.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
REQ_IDW, 2, width of grant_id; must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has a byte pending
req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
req_ready  output  NUM_REQ  bit i: byte from requester i accepted this cycle (combinational)
tx_start  output  1  to uart_tx start; registered one-cycle pulse
tx_data  output  8  to uart_tx data_in; registered, stable from the tx_start cycle until the next accept
tx_busy  input  1  from uart_tx busy
grant_id  output  REQ_IDW  index of the last accepted requester
active  output  1  high from accept until uart_tx busy falls

Behaviour:
- Reset (synchronous, active-high) values: tx_start=0, tx_data=0, grant_id=0, active=0, state=IDLE, rr_ptr=0. req_ready is 0 whenever state≠IDLE.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[winner]=1 only if tx_busy=0. At most one req_ready bit is high in any cycle.
  - On a transfer (valid & ready): latch tx_data=req_data[winner], grant_id=winner, active=1, rr_ptr=(winner+1) mod NUM_REQ, next state=ISSUE.
  - No valid requests, or tx_busy=1: stay in IDLE; no req_ready; rr_ptr unchanged.
- ISSUE: tx_start=1 for exactly this one cycle; next state=WAIT_BUSY.
- WAIT_BUSY: tx_start=0. If tx_busy=1, go to WAIT_DONE; otherwise stay.
- WAIT_DONE: when tx_busy=0, set active=0 and go to IDLE. The next accept can occur in that same IDLE cycle.
- Latency:
  - Accept at cycle N gives tx_start at N+1; uart_tx busy rises at N+2.
  - Minimum spacing between accepts is one full frame plus 3 cycles.
- Fairness: a requester holding valid continuously waits at most NUM_REQ-1 frames.
- Boundary conditions:
  - All requesters valid simultaneously: grants rotate 0,1,2,3,0,… starting from rr_ptr.
  - A single requester asserting valid back-to-back is granted every time.
  - Requesters must hold valid and data until ready. If valid drops before acceptance, the arbiter re-picks next cycle with no side effects.
  - req_data changing after acceptance does not affect tx_data.
  - tx_busy already high in IDLE (uart_tx still finishing): no grant until it falls.
  - Reset asserted in any state: outputs return to reset values on the next edge; any in-flight byte is dropped with no retry. uart_tx must share the same reset.
  - NUM_REQ not a power of 2: the rr_ptr wrap is explicit (NUM_REQ-1 → 0), never a natural overflow.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - Adds output port arb_err (1 bit, reset 0) and a 3-bit watchdog counter, cleared on entry to WAIT_BUSY.
  - If tx_busy is not seen high within 4 cycles in WAIT_BUSY: arb_err pulses high for 1 cycle, active=0, state goes to IDLE, and the byte is dropped.
- Undefined:
  - No arb_err port and no counter.
  - WAIT_BUSY waits indefinitely.

Test Plan:
- Reset with req_valid=4'b0000 → tx_start=0, active=0, req_ready=0, grant_id=0 held for 10 cycles.
- Single request: req_valid=4'b0100, data2=8'hA5, tx_busy=0 → req_ready=4'b0100 at cycle N; tx_start=1 and tx_data=8'hA5 at N+1; grant_id=2.
- All four valid (data 8'h10/8'h11/8'h12/8'h13) with a uart_tx model (busy 1 for 10 ticks) → bytes sent in order 10,11,12,13,10; each accept follows busy falling.
- Requester 1 drops valid before acceptance while requester 3 is valid, rr_ptr=1 → requester 3 granted; no tx_start for requester 1.
- Reset asserted during WAIT_DONE → next edge: tx_start=0, active=0, state=IDLE, rr_ptr=0; first grant after release goes to the lowest valid index.
- With UART_ARB_TIMEOUT_EN, tx_busy tied 0 after accept → arb_err one-cycle pulse 4 cycles into WAIT_BUSY; the arbiter then accepts the next request.
